// File: rtl/stage5ro_pkg.sv
// Shared instruction-set definitions for the writeback stage: opclass codes,
// opclass field position, FSM state encodings and opclass decode helpers.
package stage5ro_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_NREGS  = 16;
    localparam int DEF_CNT_W  = 32;

    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 20;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ALU_R = 4'h1;
    localparam logic [3:0] OPC_ALU_I = 4'h2;
    localparam logic [3:0] OPC_LOAD  = 4'h3;
    localparam logic [3:0] OPC_CMP   = 4'h4;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    function automatic logic opc_writes_reg(input logic [3:0] opc);
        return (opc == OPC_ALU_R) || (opc == OPC_ALU_I) || (opc == OPC_LOAD);
    endfunction

    function automatic logic opc_writes_flags(input logic [3:0] opc);
        return (opc == OPC_ALU_R) || (opc == OPC_ALU_I) || (opc == OPC_CMP);
    endfunction

endpackage

// File: rtl/stage5ro_regfile.sv
// Architectural register file: one write port, two combinational read ports
// that forward the in-flight write data when the addresses match.
module stage5ro_regfile
    import stage5ro_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Forwarding gives the decode stage same-cycle visibility of the commit.
    assign rd_data_a = (we && (rd_addr_a == waddr)) ? wdata : regs[rd_addr_a];
    assign rd_data_b = (we && (rd_addr_b == waddr)) ? wdata : regs[rd_addr_b];

endmodule

// File: rtl/stage5ro.sv
// Writeback stage: commits results to the register file and flags register,
// counts retired instructions and stops the pipeline on HALT.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_RUN    | retiring whenever enable_in is high
//   ST_HALTED | HALT retired; all inputs ignored until rst
module stage5ro
    import stage5ro_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_in,
    output logic              enable_out,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [3:0]        flags_in,
    input  logic [3:0]        reg_waddr_in,
    input  logic [3:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [3:0]        flags_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [CNT_W-1:0]  retire_count,
    output logic              halted
);

    state_t     state;
    logic [3:0] opc;
    logic       retire;
    logic       reg_we;
    logic       unused_instr_bits;

    assign opc               = instr_in[OPC_MSB:OPC_LSB];
    assign unused_instr_bits = ^instr_in[OPC_LSB-1:0];
    assign retire            = enable_in && (state == ST_RUN);
    assign reg_we            = retire && opc_writes_reg(opc);
    assign enable_out        = retire;

    stage5ro_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (4)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (reg_we),
        .waddr     (reg_waddr_in),
        .wdata     (result_in),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            halted       <= 1'b0;
            flags_out    <= '0;
            pc_out       <= '0;
            retire_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (enable_in) begin
                        pc_out       <= pc_in;
                        retire_count <= retire_count + CNT_W'(1);
                        if (opc_writes_flags(opc)) begin
                            flags_out <= flags_in;
                        end
                        // HALT itself retires but writes nothing.
                        if (opc == OPC_HALT) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stage5ro.md
Name: stage5ro

Overview:
- Register-output / writeback stage. Sits directly downstream of the register-address stage and consumes its latched pc, instr, result, flags and reg_waddr.
- Owns the architectural register file (16 x 24-bit) and the architectural flags register, and commits results to them.
- Tracks retired instructions and halts the pipeline on a HALT instruction.
- Provides two combinational read ports with write-through bypass for the decode/operand stages.

Parameters:
DATA_W, 24, datapath and register width
NREGS, 16, register count (address width 4)
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
enable_in  in  1  upstream stage valid/advance
enable_out  out  1  enable_in gated by not-halted
pc_in  in  24  PC from RA stage
instr_in  in  24  instruction from RA stage
result_in  in  24  result from RA stage
flags_in  in  4  flags from RA stage
reg_waddr_in  in  4  destination register from RA stage
rd_addr_a  in  4  read port A address
rd_data_a  out  24  read port A data
rd_addr_b  in  4  read port B address
rd_data_b  out  24  read port B data
flags_out  out  4  architectural flags register
pc_out  out  24  PC of last retired instruction
retire_count  out  32  retired-instruction counter
halted  out  1  high in HALTED state

Behaviour:
- Decode is from opclass = instr_in[23:20]:
  - NOP = 4'h0
  - ALU_R = 4'h1, ALU_I = 4'h2: write register and flags
  - LOAD = 4'h3: write register only
  - CMP = 4'h4: write flags only
  - HALT = 4'hF
  - Any other value retires as NOP.
- State machine has two states, RUN and HALTED.
- Retire condition: enable_in = 1 and state = RUN. On each retire:
  - pc_out <= pc_in
  - retire_count <= retire_count + 1, wrapping modulo 2^CNT_W with no saturation
  - register write class: regs[reg_waddr_in] <= result_in. All 16 registers are writable, including R0.
  - flag class: flags_out <= flags_in
  - HALT: state <= HALTED. The HALT instruction itself retires (counted, pc_out updated) and writes nothing.
- HALTED state:
  - All inputs are ignored; no register, flag, counter or pc_out change.
  - Leaves only via rst.
- enable_out = enable_in & (state == RUN), combinational from the registered state. It is therefore still high in the cycle HALT is presented.
- halted = (state == HALTED), registered.
- enable_in = 0 in RUN: no state change.
- Read ports are combinational:
  - rd_data_x = regs[rd_addr_x].
  - Bypass: if a register write retires this cycle and rd_addr_x == reg_waddr_in, then rd_data_x = result_in.
  - Both ports may read the same address simultaneously.
- Commit latency: 1 cycle (visible through regs and flags_out on the cycle after the edge). Same-cycle visibility comes only via bypass.
- Reset, asynchronous and also effective mid-operation:
  - all regs, flags_out, pc_out and retire_count = 0
  - state = RUN, halted = 0
  - enable_out follows enable_in
- Back-to-back writes to the same register: the later one wins on each edge. No write hazard, one write per cycle.

Decomposition:
- Opclass constants (OPC_NOP, OPC_ALU_R, OPC_ALU_I, OPC_LOAD, OPC_CMP, OPC_HALT), the opclass field position [23:20], and the state encodings go in the shared instruction-set include (iset.vh).
- One sub-module is natural: stage5ro_regfile (16x24, one write port, two bypassed read ports, async reset clear).
- The FSM, flags register and counter stay in stage5ro.

Test Plan:
- Reset then idle (enable_in = 0 for 5 cycles) -> all outputs 0, halted = 0, rd_data_a/b = 0 for every address.
- Retire ALU_I (instr 24'h2_03000, waddr 3, result 24'h00ABCD, flags 4'b0101) -> next cycle: R3 = 00ABCD, flags_out = 0101, retire_count = 1, pc_out = pc_in. In the same cycle with rd_addr_a = 3, rd_data_a = 00ABCD via bypass.
- LOAD to R5 with result 24'h123456, then CMP with flags 4'b1000 -> R5 = 123456 and flags unchanged by LOAD; flags = 1000 after CMP; R5 unchanged by CMP; retire_count = 2.
- HALT at pc 24'h000010, followed by ALU_R to R1 with result 24'hFFFFFF -> enable_out high in the HALT cycle and low afterwards; halted = 1; R1 stays 0; retire_count = 1; pc_out = 000010.
- Assert rst mid-stream after 3 retires, with no clock edge -> outputs clear immediately to 0. Resume and retire 1 -> retire_count = 1.
- Preload retire_count to 32'hFFFFFFFF (force), then retire a NOP -> retire_count = 0, with no register or flag change.
